// File: rtl/fwd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_ctrl_if
//  Description : Decode-stage hazard inputs and forwarding/stall outputs
//                shared between the pipeline front end and fwd_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fwd_ctrl_if #(
    parameter int XLEN_SEL = 2,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [4:0]          id_rs1;
    logic [4:0]          id_rs2;
    logic [4:0]          id_rd;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                flush;
    logic [XLEN_SEL-1:0] fwd_a;
    logic [XLEN_SEL-1:0] fwd_b;
    logic                stall;
    logic [CNT_W-1:0]    stall_cnt;

    // Pipeline side: presents the decode instruction, consumes selects/stall
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_ctrl
//  Description : Operand-forwarding and load-use stall controller. Tracks the
//                EX/MEM/WB/RT stages and selects the youngest producer for
//                each EX source operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_ctrl #(
    parameter int XLEN_SEL = 2,   // only 2 is supported (4:1 operand muxes)
    parameter int CNT_W    = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fwd_ctrl_if.slave   bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_t;

    localparam stage_t c_BUBBLE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

    stage_t           ex_q, mem_q, wb_q, rt_q;
    stage_t           ex_d;
    logic [4:0]       ex_rs1_q, ex_rs2_q;
    logic [4:0]       ex_rs1_d, ex_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             w_stall;

    // A stage is a forwarding source only if it really writes a non-x0 register
    function automatic logic f_writes(input stage_t s);
        return s.valid & s.reg_write & (s.rd != 5'd0);
    endfunction

    // Youngest matching producer wins; an empty EX never forwards
    function automatic logic [XLEN_SEL-1:0] f_sel(
        input logic       ex_valid,
        input logic [4:0] rs,
        input stage_t     m,
        input stage_t     w,
        input stage_t     r
    );
        if (!ex_valid)                     return 2'b00;
        else if (f_writes(m) && m.rd == rs) return 2'b01;
        else if (f_writes(w) && w.rd == rs) return 2'b10;
        else if (f_writes(r) && r.rd == rs) return 2'b11;
        else                               return 2'b00;
    endfunction

    // Load in EX feeding the decode instruction; flush squashes ID so it wins
    always_comb begin
        w_stall = bus.id_valid & ~bus.flush
                & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
                & ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
    end

    // Next EX contents: decode instruction, or a bubble on stall/flush
    always_comb begin
        ex_d     = '{valid: bus.id_valid, rd: bus.id_rd,
                     reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
        ex_rs1_d = bus.id_rs1;
        ex_rs2_d = bus.id_rs2;
        if (w_stall || bus.flush) begin
            ex_d     = c_BUBBLE;
            ex_rs1_d = 5'd0;
            ex_rs2_d = 5'd0;
        end
    end

    // Saturating count of stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stage shift is never blocked; reset drops all in-flight tracking at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= c_BUBBLE;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            mem_q       <= c_BUBBLE;
            wb_q        <= c_BUBBLE;
            rt_q        <= c_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            rt_q        <= wb_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Selects depend only on stage registers, never on the decode inputs
    always_comb begin
        bus.fwd_a = f_sel(ex_q.valid, ex_rs1_q, mem_q, wb_q, rt_q);
        bus.fwd_b = f_sel(ex_q.valid, ex_rs2_q, mem_q, wb_q, rt_q);
    end

    assign bus.stall     = w_stall;
    assign bus.stall_cnt = stall_cnt_q;

    // mem_read is carried down the pipe with each instruction, but only the
    // EX copy matters for hazard detection
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, mem_q.mem_read, wb_q.mem_read, rt_q.mem_read};

endmodule
`default_nettype wire

// File: tb/tb_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_ctrl
//  Description : Self-checking bench for fwd_ctrl. Keeps a list of the last
//                four instructions that entered EX and derives selects from
//                producer distance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fwd_ctrl_if #(.XLEN_SEL(2), .CNT_W(16)) bus ();

    fwd_ctrl #(.XLEN_SEL(2), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    instr_t pipe [4];   // pipe[k] = instruction that entered EX k cycles ago
    int     m_cnt;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) pipe[i] = '0;
        m_cnt = 0;
    endfunction

    // Select code equals the distance of the nearest producer (1..3), else 0
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!pipe[0].v) return 2'b00;
        for (int age = 1; age <= 3; age++) begin
            if (pipe[age].v && pipe[age].rw && pipe[age].rd != 5'd0 && pipe[age].rd == rs)
                return 2'(age);
        end
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        return bus.id_valid && !bus.flush && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0 &&
               (pipe[0].rd == bus.id_rs1 || pipe[0].rd == bus.id_rs2);
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock edge and mirror it in the model
    task automatic tick();
        logic   st;
        instr_t nx;
        st = m_stall();
        nx = '{v: bus.id_valid, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
               rw: bus.id_reg_write, mr: bus.id_mem_read};
        if (st || bus.flush) nx = '0;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = nx;
            if (st && m_cnt < 65535) m_cnt++;
        end
        #2;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        set_id(1'b1, rs1, rs2, rd, rw, mr, 1'b0);
        tick();
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        set_id(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset fwd_a got %b exp 00", bus.fwd_a); end
            n_cmp++; if (bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset fwd_b got %b exp 00", bus.fwd_b); end
            n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset stall got %b exp 0", bus.stall); end
            n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset stall_cnt got %0d exp 0", bus.stall_cnt); end
            tick();
        end
        nop();
        rst_n = 1'b1;
    endtask

    task automatic test_alu_pair();
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
        issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);   // sub x6, x5, x5
        nop();
        n_cmp++; if (bus.fwd_a !== 2'b01) begin n_fail++; $display("FAIL alu_pair fwd_a got %b exp 01", bus.fwd_a); end
        n_cmp++; if (bus.fwd_b !== 2'b01) begin n_fail++; $display("FAIL alu_pair fwd_b got %b exp 01", bus.fwd_b); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu_pair stall got %b exp 0", bus.stall); end
        drain();
    endtask

    task automatic test_distance();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
        for (int gap = 0; gap < 4; gap++) begin
            issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
            for (int k = 0; k < gap; k++) issue(5'd1, 5'd2, 5'd20, 1'b1, 1'b0);
            issue(5'd7, 5'd1, 5'd21, 1'b1, 1'b0);
            nop();
            n_cmp++;
            if (bus.fwd_a !== exp_sel[gap])
                begin n_fail++; $display("FAIL distance gap=%0d fwd_a got %b exp %b", gap, bus.fwd_a, exp_sel[gap]); end
            drain();
        end
    endtask

    task automatic test_load_use();
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL load_use cnt_before got %0d exp 0", bus.stall_cnt); end
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);   // lw x9
        set_id(1'b1, 5'd1, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL load_use stall1 got %b exp 1", bus.stall); end
        tick();
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_use stall2 got %b exp 0", bus.stall); end
        n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use cnt_after got %0d exp 1", bus.stall_cnt); end
        tick();
        nop();
        n_cmp++; if (bus.fwd_b !== 2'b10) begin n_fail++; $display("FAIL load_use fwd_b got %b exp 10", bus.fwd_b); end
        n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL load_use fwd_a got %b exp 00", bus.fwd_a); end
        drain();
    endtask

    task automatic test_priority_x0();
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
        nop();
        n_cmp++; if (bus.fwd_a !== 2'b01) begin n_fail++; $display("FAIL priority fwd_a got %b exp 01", bus.fwd_a); end
        drain();
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);   // write to x0
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        nop();
        n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL x0 fwd_a got %b exp 00", bus.fwd_a); end
        n_cmp++; if (bus.fwd_b !== 2'b00) begin n_fail++; $display("FAIL x0 fwd_b got %b exp 00", bus.fwd_b); end
        drain();
    endtask

    task automatic test_flush_over_stall();
        issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);   // lw x9
        set_id(1'b1, 5'd9, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush stall got %b exp 0", bus.stall); end
        tick();
        nop();
        n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush stall_cnt got %0d exp 1", bus.stall_cnt); end
        // The squashed reader would see fwd_a=01 from the load if it had entered EX
        n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL flush bubble fwd_a got %b exp 00", bus.fwd_a); end
        drain();
    endtask

    task automatic test_random();
        logic [1:0] ea, eb;
        logic       es;
        for (int c = 0; c < 400; c++) begin
            set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            ea = m_fwd(pipe[0].rs1);
            eb = m_fwd(pipe[0].rs2);
            es = m_stall();
            n_cmp++; if (bus.fwd_a !== ea) begin n_fail++; $display("FAIL random[%0d] fwd_a got %b exp %b", c, bus.fwd_a, ea); end
            n_cmp++; if (bus.fwd_b !== eb) begin n_fail++; $display("FAIL random[%0d] fwd_b got %b exp %b", c, bus.fwd_b, eb); end
            n_cmp++; if (bus.stall !== es) begin n_fail++; $display("FAIL random[%0d] stall got %b exp %b", c, bus.stall, es); end
            n_cmp++;
            if (bus.stall_cnt !== 16'(m_cnt))
                begin n_fail++; $display("FAIL random[%0d] stall_cnt got %0d exp %0d", c, bus.stall_cnt, m_cnt); end
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
            set_id(1'b1, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
        end
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        nop();
        n_cmp++; if (bus.fwd_a !== 2'b01) begin n_fail++; $display("FAIL async pre fwd_a got %b exp 01", bus.fwd_a); end
        n_cmp++; if (bus.stall_cnt !== 16'd5) begin n_fail++; $display("FAIL async pre stall_cnt got %0d exp 5", bus.stall_cnt); end
        rst_n = 1'b0;                           // between edges
        #1;
        n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL async fwd_a got %b exp 00", bus.fwd_a); end
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL async stall_cnt got %0d exp 0", bus.stall_cnt); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL async stall got %b exp 0", bus.stall); end
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_alu_pair();
        test_distance();
        test_load_use();
        test_priority_x0();
        test_flush_over_stall();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
